uart_mmio_bridge: RTL and testbench

//   Memory-mapped I/O slave between the MIPS150 data port (dcache_addr/we/re/din) and the

---
 rtl/uart_mmio_bridge.sv | 146 ++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped slave that couples the CPU data port to a
// UART byte-stream handshake. RX and TX bytes are buffered in small FIFOs;
// status, data and a free-running cycle counter are exposed in a 32-byte window.
module uart_mmio_bridge #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] din,
  input  logic        stall,
  output logic [31:0] dout,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] OFF_RX_CTRL = 3'd0;
  localparam logic [2:0] OFF_RX_DATA = 3'd1;
  localparam logic [2:0] OFF_TX_CTRL = 3'd2;
  localparam logic [2:0] OFF_TX_DATA = 3'd3;
  localparam logic [2:0] OFF_CYCLE   = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_rd_ptr, rx_wr_ptr, tx_rd_ptr, tx_wr_ptr;
  logic [CW-1:0] rx_count, tx_count;
  logic [31:0]   cycle_cnt;
  logic          ovf;

  logic          win;
  logic [2:0]    off;
  logic          rd_acc, wr_acc;
  logic          rx_push, rx_pop;
  logic          tx_push_req, tx_push, tx_pop, tx_drop;
  logic          cycle_wr, status_wr;
  logic [31:0]   rdata;
  logic          unused_bits;

  // Only the word offset and the low data byte carry meaning.
  assign unused_bits = ^{addr[1:0], din[31:8]};

  // Request qualification and FIFO handshake decode.
  always_comb begin
    win         = (addr[31:5] == BASE_ADDR[31:5]);
    off         = addr[4:2];
    rd_acc      = re & ~stall & win;
    wr_acc      = (|we) & ~stall & win;
    rx_ready    = ~rst & (rx_count != FULL_CNT);
    tx_valid    = ~rst & (tx_count != '0);
    tx_data     = tx_mem[tx_rd_ptr];
    rx_push     = rx_valid & rx_ready;
    rx_pop      = rd_acc & (off == OFF_RX_DATA) & (rx_count != '0);
    tx_pop      = tx_valid & tx_ready;
    tx_push_req = wr_acc & (off == OFF_TX_DATA);
    // A full TX FIFO still takes the byte when the UART drains one this cycle.
    tx_push     = tx_push_req & ((tx_count != FULL_CNT) | tx_pop);
    tx_drop     = tx_push_req & ~tx_push;
    cycle_wr    = wr_acc & (off == OFF_CYCLE);
    status_wr   = wr_acc & (off == OFF_STATUS);
  end

  // Register read mux; values are the pre-write state of this cycle.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_RX_CTRL: rdata = {31'b0, rx_count != '0};
      OFF_RX_DATA: rdata = (rx_count != '0) ? {24'b0, rx_mem[rx_rd_ptr]} : 32'b0;
      OFF_TX_CTRL: rdata = {31'b0, tx_count != FULL_CNT};
      OFF_CYCLE:   rdata = cycle_cnt;
      OFF_STATUS:  rdata = {ovf, 15'b0, 8'(tx_count), 8'(rx_count)};
      default:     rdata = '0;
    endcase
  end

  // FIFO storage; stale entries are harmless because counts gate every use.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= din[7:0];
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Read data/hit capture, cycle counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      hit       <= 1'b0;
      cycle_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      if (re & ~stall) begin
        dout <= win ? rdata : 32'b0;
        hit  <= win;
      end
      cycle_cnt <= cycle_wr ? 32'b0 : cycle_cnt + 32'd1;
      if (tx_drop)        ovf <= 1'b1;
      else if (status_wr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: a vector table for single-cycle
// register accesses plus hand-written sequences for the multi-cycle paths.
module tb_uart_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] din;
  logic        stall;
  logic [31:0] dout;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_RX_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX_DATA = 32'h8000_0004;
  localparam logic [31:0] A_TX_CTRL = 32'h8000_0008;
  localparam logic [31:0] A_TX_DATA = 32'h8000_000C;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
  localparam logic [31:0] A_STATUS  = 32'h8000_0014;

  uart_mmio_bridge #(.FIFO_DEPTH(8), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .din(din),
    .stall(stall), .dout(dout), .hit(hit), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] din;
    logic        stall;
    logic [31:0] exp_dout;
    logic        exp_hit;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic r,
                     input logic [31:0] d, input logic s);
    addr = a; we = w; re = r; din = d; stall = s;
    step();
    we = 4'h0; re = 1'b0; stall = 1'b0; din = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus(a, 4'h0, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(a, 4'hF, 1'b0, d, 1'b0);
  endtask

  initial begin
    logic [31:0] cval;
    logic [7:0]  expb;

    vecs[0]  = '{A_RX_CTRL,   4'h0, 1'b1, 32'h0,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{A_TX_CTRL,   4'h0, 1'b1, 32'h0,  1'b0, 32'h0000_0001, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{A_TX_DATA,   4'hF, 1'b0, 32'h41, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 8'h41};
    vecs[3]  = '{A_TX_DATA,   4'h1, 1'b0, 32'h42, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 8'h41};
    vecs[4]  = '{A_STATUS,    4'h0, 1'b1, 32'h0,  1'b0, 32'h0000_0200, 1'b1, 1'b1, 8'h41};
    vecs[5]  = '{A_TX_DATA,   4'hF, 1'b0, 32'h43, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 8'h41};
    vecs[6]  = '{32'h8000_001C, 4'hF, 1'b0, 32'hFF, 1'b0, 32'h0000_0200, 1'b1, 1'b1, 8'h41};
    vecs[7]  = '{A_STATUS,    4'h0, 1'b1, 32'h0,  1'b0, 32'h0000_0200, 1'b1, 1'b1, 8'h41};
    vecs[8]  = '{A_RX_CTRL,   4'h0, 1'b1, 32'h0,  1'b1, 32'h0000_0200, 1'b1, 1'b1, 8'h41};
    vecs[9]  = '{32'h9000_0000, 4'h0, 1'b1, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'h41};
    vecs[10] = '{32'h8000_0018, 4'h0, 1'b1, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'h41};
    vecs[11] = '{32'h8000_0028, 4'h0, 1'b1, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 8'h41};
    vecs[12] = '{A_RX_DATA,   4'h0, 1'b1, 32'h0,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'h41};

    rst = 1'b1; addr = 32'h0; we = 4'h0; re = 1'b0; din = 32'h0; stall = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;

    // Reset held for three cycles.
    repeat (3) step();
    chk("rst_dout", dout, 32'h0);
    chk("rst_hit", {31'b0, hit}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
    rst = 1'b0;
    step();
    chk("rel_rx_ready", {31'b0, rx_ready}, 32'h1);

    // Table of single-cycle accesses.
    for (int i = 0; i < 13; i++) begin
      bus(vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].din, vecs[i].stall);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_txv", i), {31'b0, tx_valid}, {31'b0, vecs[i].exp_txv});
      if (vecs[i].exp_txv)
        chk($sformatf("vec%0d_txd", i), {24'b0, tx_data}, {24'b0, vecs[i].exp_txd});
    end

    // TX drain of the two queued bytes.
    tx_ready = 1'b1;
    chk("txdrain_b0", {24'b0, tx_data}, 32'h41);
    step();
    chk("txdrain_b1", {24'b0, tx_data}, 32'h42);
    chk("txdrain_v1", {31'b0, tx_valid}, 32'h1);
    step();
    tx_ready = 1'b0;
    chk("txdrain_empty", {31'b0, tx_valid}, 32'h0);

    // TX overflow: nine writes into a depth-8 FIFO.
    for (int i = 1; i <= 9; i++) wr(A_TX_DATA, 32'(i));
    rd(A_TX_CTRL);
    chk("ovf_tx_ctrl", dout, 32'h0);
    rd(A_STATUS);
    chk("ovf_status", dout, 32'h8000_0800);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(i)});
      step();
    end
    tx_ready = 1'b0;
    chk("ovf_drained", {31'b0, tx_valid}, 32'h0);
    bus(A_STATUS, 4'hF, 1'b1, 32'h0, 1'b0);
    chk("ovf_rw_status", dout, 32'h8000_0000);
    rd(A_STATUS);
    chk("ovf_cleared", dout, 32'h0);

    // Full TX FIFO: push coinciding with UART pop is accepted.
    for (int i = 0; i < 8; i++) wr(A_TX_DATA, 32'hA0 + 32'(i));
    tx_ready = 1'b1;
    wr(A_TX_DATA, 32'h99);
    tx_ready = 1'b0;
    rd(A_STATUS);
    chk("fullpop_status", dout, 32'h0000_0800);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expb = (i < 7) ? 8'(8'hA1 + i) : 8'h99;
      chk($sformatf("fullpop_b%0d", i), {24'b0, tx_data}, {24'b0, expb});
      step();
    end
    tx_ready = 1'b0;
    chk("fullpop_empty", {31'b0, tx_valid}, 32'h0);

    // RX path: two bytes in, three reads out.
    chk("rx_ready_idle", {31'b0, rx_ready}, 32'h1);
    rx_valid = 1'b1; rx_data = 8'h7a;
    step();
    rx_data = 8'h80;
    step();
    rx_valid = 1'b0;
    rd(A_RX_CTRL);
    chk("rx_ctrl_1", dout, 32'h1);
    rd(A_RX_DATA);
    chk("rx_data_7a", dout, 32'h7a);
    rd(A_RX_DATA);
    chk("rx_data_80", dout, 32'h80);
    rd(A_RX_DATA);
    chk("rx_data_empty", dout, 32'h0);
    rd(A_RX_CTRL);
    chk("rx_ctrl_0", dout, 32'h0);

    // Stalled RX_DATA read neither pops nor updates dout.
    rx_valid = 1'b1; rx_data = 8'h55;
    step();
    rx_valid = 1'b0;
    bus(A_RX_DATA, 4'h0, 1'b1, 32'h0, 1'b1);
    chk("stall_hold", dout, 32'h0);
    rd(A_RX_CTRL);
    chk("stall_nopop", dout, 32'h1);
    rd(A_RX_DATA);
    chk("stall_data", dout, 32'h55);

    // RX full, pop alongside an unaccepted rx_valid, then push+pop together.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("rxfull_ready", {31'b0, rx_ready}, 32'h0);
    rx_valid = 1'b1; rx_data = 8'hEE;
    rd(A_RX_DATA);
    rx_valid = 1'b0;
    chk("rxfull_pop", dout, 32'h10);
    rd(A_STATUS);
    chk("rxfull_cnt7", dout, 32'h0000_0007);
    chk("rxfull_ready7", {31'b0, rx_ready}, 32'h1);
    rx_valid = 1'b1; rx_data = 8'h20;
    rd(A_RX_DATA);
    rx_valid = 1'b0;
    chk("rxpp_pop", dout, 32'h11);
    rd(A_STATUS);
    chk("rxpp_cnt7", dout, 32'h0000_0007);
    for (int i = 0; i < 7; i++) begin
      expb = (i < 6) ? 8'(8'h12 + i) : 8'h20;
      rd(A_RX_DATA);
      chk($sformatf("rxpp_drain%0d", i), dout, {24'b0, expb});
    end

    // Cycle counter: clear, idle 100 cycles, read.
    wr(A_CYCLE, 32'h1234);
    repeat (100) step();
    rd(A_CYCLE);
    cval = dout;
    checks++;
    if (cval < 32'd100 || cval > 32'd102) begin
      errors++;
      $display("FAIL cycle_range act=%0d exp=100..102", cval);
    end
    bus(A_CYCLE, 4'hF, 1'b1, 32'h0, 1'b0);
    chk("cycle_rw_old", dout, cval + 32'd1);
    rd(A_CYCLE);
    chk("cycle_cleared", dout, 32'h0);

    // Reset in the middle of traffic discards buffered bytes.
    wr(A_TX_DATA, 32'h5A);
    wr(A_TX_DATA, 32'h5B);
    rx_valid = 1'b1; rx_data = 8'h66;
    step();
    rx_valid = 1'b0;
    rd(A_TX_CTRL);
    chk("pre_rst_dout", dout, 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("midrst_rx_ready", {31'b0, rx_ready}, 32'h0);
    chk("midrst_dout", dout, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_rx_ready", {31'b0, rx_ready}, 32'h1);
    chk("postrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    rd(A_STATUS);
    chk("postrst_status", dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
